dense_backward: RTL and testbench
=================================

# dense_backward

Sequential backward-pass engine for the dense (fully connected) layer. Given the layer's weights, its forward inputs and the upstream output gradient, it computes the input gradient `grad_in = grad_out · W` and the weight gradient `grad_w = grad_outᵀ · X` using a single shared signed multiply-accumulate unit. It sits beside the combinational forward dense layer in the training datapath and is driven by a start/done handshake from the training controller.

## Interface
- `B`, 2: batch size
- `M`, 3: output features (rows of W)
- `N`, 4: input features (columns of W)
- `WIDTH`, 16: signed operand width; results are `2*WIDTH`
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a backward pass; accepted only in IDLE
- `weights`  in  signed [WIDTH-1:0] [M][N]  layer weights W
- `inputs`  in  signed [WIDTH-1:0] [B][N]  forward inputs X
- `grad_out`  in  signed [WIDTH-1:0] [B][M]  upstream gradient dY
- `busy`  out  1  high while computing
- `done`  out  1  one-cycle pulse when both gradients are complete
- `grad_in`  out  signed [2*WIDTH-1:0] [B][N]  dX[b][j] = Σ_i dY[b][i]·W[i][j]
- `grad_w`  out  signed [2*WIDTH-1:0] [M][N]  dW[i][j] = Σ_b dY[b][i]·X[b][j]

## Operation
- FSM states: IDLE, GRAD_IN, GRAD_W, DONE.
- IDLE: `busy`=0. On `start`=1, capture `weights`, `inputs` and `grad_out` into internal registers, clear all `grad_in`/`grad_w` entries and the accumulator to 0, zero the loop counters, and go to GRAD_IN. After capture, the inputs may change freely.
- GRAD_IN: one MAC per cycle. Loop order is `b` outer, `j` middle, `i` inner. On the cycle where `i==M-1`, write `acc + dY[b][i]·W[i][j]` to `grad_in[b][j]` and clear `acc`. After B·N·M cycles, go to GRAD_W.
- GRAD_W: one MAC per cycle. Loop order is `i` outer, `j` middle, `b` inner. On the cycle where `b==B-1`, write the sum to `grad_w[i][j]` and clear `acc`. After M·N·B cycles, go to DONE.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then return to IDLE.
- Arithmetic:
  - Each product is signed WIDTH×WIDTH, giving a full `2*WIDTH` result.
  - The accumulator is `2*WIDTH` signed and wraps modulo 2^(2·WIDTH). There is no saturation and no overflow flag.
- Output stability:
  - Outputs are registers that update element by element during the computation.
  - They are valid from the DONE cycle onward.
  - They hold until the next accepted `start`.
- `start` in GRAD_IN, GRAD_W or DONE is ignored. It is not queued.
- Degenerate parameters are illegal: B, M, N ≥ 1.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, all `grad_in` and `grad_w` entries 0, accumulator and counters 0.
- `rst` has priority over everything, including a `start` in the same cycle.
- `rst` in mid-operation aborts to IDLE with all outputs zeroed, and no `done` pulse is produced.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
  - `busy` is 1 from E0 until edge E0+2·B·M·N.
  - `done` is 1 for the single cycle following edge E0+2·B·M·N. With default parameters that is 48 edges after E0.
- `grad_in` is final by edge E0+B·M·N. `grad_w` is final by edge E0+2·B·M·N.
- A new `start` is accepted at the earliest one cycle after `done`, i.e. in IDLE. Back-to-back passes therefore cost 2·B·M·N+1 cycles, excluding the IDLE cycle.

## Test plan
- **Basic pass:** defaults, W all 1, dY[b][i]=b+1, X[b][j]=j, pulse `start` → `done` 48 edges later; `grad_in[0][*]`=3, `grad_in[1][*]`=6; `grad_w[i][j]`=3j (0, 3, 6, 9) for every i.
- **Signed and wrap:** WIDTH=16, all W=-32768, all dY=-32768, all X=1 → `grad_in` every entry = 3·2^30, which wraps to -1073741824; `grad_w` every entry = -65536.
- **Input capture:** start the basic pass, then change `weights`/`inputs`/`grad_out` to 0 the cycle after E0 → results are identical to the basic pass.
- **Ignored start:** pulse `start` again at E0+10 and in the DONE cycle → exactly one `done` pulse, correct results, FSM back in IDLE.
- **Reset mid-operation:** assert `rst` at E0+30 → next cycle `busy`=0, all outputs 0, no `done`. A subsequent `start` then produces correct results.
- **Reset/start collision:** `rst` and `start` high in the same cycle → the block stays in IDLE and `busy` stays 0.

Source files
------------

// File: rtl/dense_backward.sv
// rtl/dense_backward.sv - sequential dense-layer backward pass (grad_in, grad_w) on one shared MAC
module dense_backward #(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [M-1:0][N-1:0][WIDTH-1:0]         weights,
  input  logic [B-1:0][N-1:0][WIDTH-1:0]         inputs,
  input  logic [B-1:0][M-1:0][WIDTH-1:0]         grad_out,
  output logic                                   busy,
  output logic                                   done,
  output logic [B-1:0][N-1:0][2*WIDTH-1:0]       grad_in,
  output logic [M-1:0][N-1:0][2*WIDTH-1:0]       grad_w
);

  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, GRAD_IN, GRAD_W, DONE} state_t;

  state_t state_q, next_state;

  logic [M-1:0][N-1:0][WIDTH-1:0] w_q;
  logic [B-1:0][N-1:0][WIDTH-1:0] x_q;
  logic [B-1:0][M-1:0][WIDTH-1:0] dy_q;

  // One counter per array dimension; only the nesting order differs between phases.
  logic [BW-1:0] cnt_b;
  logic [MW-1:0] cnt_i;
  logic [NW-1:0] cnt_j;
  logic          last_b, last_i, last_j;

  logic [WIDTH-1:0] op_a, op_b;
  logic [RW-1:0]    prod, acc, sum;

  assign last_b = (cnt_b == BW'(B - 1));
  assign last_i = (cnt_i == MW'(M - 1));
  assign last_j = (cnt_j == NW'(N - 1));

  // Both phases multiply dY[b][i]; the second operand is W[i][j] or X[b][j].
  always_comb begin
    op_a = dy_q[cnt_b][cnt_i];
    op_b = w_q[cnt_i][cnt_j];
    if (state_q == GRAD_W) op_b = x_q[cnt_b][cnt_j];
  end

  // Sign-extend to full result width; the low RW bits of the product are the signed product.
  assign prod = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
  assign sum  = acc + prod;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Next-state and status decode.
  always_comb begin
    next_state = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE:    if (start) next_state = GRAD_IN;
      GRAD_IN: begin
        busy = 1'b1;
        if (last_b && last_j && last_i) next_state = GRAD_W;
      end
      GRAD_W:  begin
        busy = 1'b1;
        if (last_i && last_j && last_b) next_state = DONE;
      end
      DONE:    begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, loop counters, accumulator and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      x_q     <= '0;
      dy_q    <= '0;
      grad_in <= '0;
      grad_w  <= '0;
      acc     <= '0;
      cnt_b   <= '0;
      cnt_i   <= '0;
      cnt_j   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          w_q     <= weights;
          x_q     <= inputs;
          dy_q    <= grad_out;
          grad_in <= '0;
          grad_w  <= '0;
          acc     <= '0;
          cnt_b   <= '0;
          cnt_i   <= '0;
          cnt_j   <= '0;
        end
        GRAD_IN: begin
          // b outer, j middle, i inner
          if (last_i) begin
            grad_in[cnt_b][cnt_j] <= sum;
            acc                   <= '0;
            cnt_i                 <= '0;
            cnt_j                 <= last_j ? '0 : cnt_j + NW'(1);
            if (last_j) cnt_b <= last_b ? '0 : cnt_b + BW'(1);
          end else begin
            acc   <= sum;
            cnt_i <= cnt_i + MW'(1);
          end
        end
        GRAD_W: begin
          // i outer, j middle, b inner
          if (last_b) begin
            grad_w[cnt_i][cnt_j] <= sum;
            acc                  <= '0;
            cnt_b                <= '0;
            cnt_j                <= last_j ? '0 : cnt_j + NW'(1);
            if (last_j) cnt_i <= last_i ? '0 : cnt_i + MW'(1);
          end else begin
            acc   <= sum;
            cnt_b <= cnt_b + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_backward.sv
// tb/tb_dense_backward.sv - self-checking bench for dense_backward
module tb_dense_backward;

  localparam int B = 2;
  localparam int M = 3;
  localparam int N = 4;
  localparam int W = 16;
  localparam int RW = 2 * W;
  localparam int PASS_CYC = 2 * B * M * N;

  logic clk = 1'b0;
  logic rst, start;
  logic [M-1:0][N-1:0][W-1:0]  weights;
  logic [B-1:0][N-1:0][W-1:0]  inputs;
  logic [B-1:0][M-1:0][W-1:0]  grad_out;
  logic                        busy, done;
  logic [B-1:0][N-1:0][RW-1:0] grad_in;
  logic [M-1:0][N-1:0][RW-1:0] grad_w;

  always #5 clk = ~clk;

  dense_backward #(.B(B), .M(M), .N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .weights(weights), .inputs(inputs), .grad_out(grad_out),
    .busy(busy), .done(done), .grad_in(grad_in), .grad_w(grad_w)
  );

  int checks = 0;
  int failures = 0;

  int w_m[M][N];
  int x_m[B][N];
  int dy_m[B][M];
  logic [RW-1:0] exp_gi[B][N];
  logic [RW-1:0] exp_gw[M][N];

  typedef struct {
    int w_fill;
    int dy_fill;
    int x_fill;
    int gi;
    int gw;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_model();
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) weights[i][j] = W'(w_m[i][j]);
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) inputs[b][j] = W'(x_m[b][j]);
    for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) grad_out[b][i] = W'(dy_m[b][i]);
  endtask

  // Matrix products by definition, 64-bit sums then reduced modulo 2^RW.
  task automatic compute_ref();
    longint s;
    for (int b = 0; b < B; b++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int i = 0; i < M; i++) s += longint'(dy_m[b][i]) * longint'(w_m[i][j]);
        exp_gi[b][j] = s[RW-1:0];
      end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int b = 0; b < B; b++) s += longint'(dy_m[b][i]) * longint'(x_m[b][j]);
        exp_gw[i][j] = s[RW-1:0];
      end
  endtask

  task automatic check_outputs(input string tag);
    for (int b = 0; b < B; b++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s grad_in[%0d][%0d]", tag, b, j), grad_in[b][j], exp_gi[b][j]);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s grad_w[%0d][%0d]", tag, i, j), grad_w[i][j], exp_gw[i][j]);
  endtask

  task automatic set_basic();
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) w_m[i][j] = 1;
    for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) x_m[b][j] = j;
    for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) dy_m[b][i] = b + 1;
    for (int j = 0; j < N; j++) begin
      exp_gi[0][j] = 3;
      exp_gi[1][j] = 6;
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) exp_gw[i][j] = RW'(3 * j);
    drive_model();
  endtask

  // One pass from start to DONE; optionally clobbers inputs after capture or
  // fires extra starts mid-pass and in the DONE cycle.
  task automatic run_pass(input string tag, input bit zero_after, input bit extra_starts);
    int lat;
    int done_cnt;
    int busy_bad;
    lat = -1;
    done_cnt = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (zero_after) begin
      weights = '0;
      inputs = '0;
      grad_out = '0;
    end
    for (int k = 1; k <= PASS_CYC + 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (k < PASS_CYC && busy !== 1'b1) busy_bad++;
      if (k >= PASS_CYC && busy !== 1'b0) busy_bad++;
      start = extra_starts && (k == 10 || done);
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(PASS_CYC));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_profile_errors"}, 64'(busy_bad), 64'd0);
    check_outputs(tag);
  endtask

  initial begin
    int cnt;

    tbl[0] = '{w_fill: 1,      dy_fill: 1,      x_fill: 1,      gi: 3,           gw: 2};
    tbl[1] = '{w_fill: -32768, dy_fill: -32768, x_fill: 1,      gi: -1073741824, gw: -65536};
    tbl[2] = '{w_fill: 2,      dy_fill: -3,     x_fill: 5,      gi: -18,         gw: -30};
    tbl[3] = '{w_fill: 0,      dy_fill: 7,      x_fill: 7,      gi: 0,           gw: 98};
    tbl[4] = '{w_fill: 32767,  dy_fill: 32767,  x_fill: 32767,  gi: -1073938429, gw: 2147352578};
    tbl[5] = '{w_fill: -1,     dy_fill: 1,      x_fill: -1,     gi: -3,          gw: -2};

    rst = 1'b1;
    start = 1'b0;
    weights = '0;
    inputs = '0;
    grad_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset grad_in zero", 64'(grad_in == '0), 64'd1);
    check("reset grad_w zero", 64'(grad_w == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) w_m[i][j] = tbl[t].w_fill;
      for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) x_m[b][j] = tbl[t].x_fill;
      for (int b = 0; b < B; b++) for (int i = 0; i < M; i++) dy_m[b][i] = tbl[t].dy_fill;
      for (int b = 0; b < B; b++) for (int j = 0; j < N; j++) exp_gi[b][j] = RW'(tbl[t].gi);
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) exp_gw[i][j] = RW'(tbl[t].gw);
      drive_model();
      run_pass($sformatf("table%0d", t), 1'b0, 1'b0);
    end

    set_basic();
    run_pass("basic", 1'b0, 1'b0);

    set_basic();
    run_pass("capture", 1'b1, 1'b0);

    set_basic();
    run_pass("ignored_start", 1'b0, 1'b1);

    // Reset in the middle of GRAD_W aborts with zeroed outputs and no done.
    set_basic();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset grad_in zero", 64'(grad_in == '0), 64'd1);
    check("midreset grad_w zero", 64'(grad_w == '0), 64'd1);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < PASS_CYC + 10; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    check("midreset no activity after abort", 64'(cnt), 64'd0);
    set_basic();
    run_pass("after_reset", 1'b0, 1'b0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("collision busy", 64'(busy), 64'd0);
    check("collision grad_in zero", 64'(grad_in == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (busy || done) cnt++;
    end
    check("collision stays idle", 64'(cnt), 64'd0);

    // Randomized passes against the arithmetic reference.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          w_m[i][j] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      for (int b = 0; b < B; b++)
        for (int j = 0; j < N; j++)
          x_m[b][j] = ($urandom_range(0, 7) == 0) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
      for (int b = 0; b < B; b++)
        for (int i = 0; i < M; i++)
          dy_m[b][i] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      compute_ref();
      drive_model();
      run_pass($sformatf("random%0d", r), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
